// File: rtl/bus_copy_dma.sv
// bus_copy_dma: copies a byte range between bus addresses, one read then one write per unit.
// Optional response timeout: define BUS_COPY_DMA_TIMEOUT_EN.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module bus_copy_dma #(
  parameter int unsigned AW = 24,
  parameter int unsigned LW = 16
`ifdef BUS_COPY_DMA_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [AW-1:0]             src,
  input  logic [AW-1:0]             dst,
  input  logic [LW-1:0]             len,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [AW-1:0]             err_addr,
  output logic [AW-1:0]             addr,
  output logic                      w_rb,
  output logic [`BUS_ACC_WIDTH-1:0] acc,
  input  logic [`BUS_WIDTH-1:0]     rdata,
  output logic [`BUS_WIDTH-1:0]     wdata,
  output logic                      req,
  input  logic                      resp,
  input  logic                      fault
);

  localparam int unsigned BW   = `BUS_WIDTH;
  localparam int unsigned ACCW = `BUS_ACC_WIDTH;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

  state_t        state;
  logic [AW-1:0] cur_src;
  logic [AW-1:0] cur_dst;
  logic [LW-1:0] rem;
  logic [2:0]    unit_n;

  logic [AW-1:0] nxt_src;
  logic [AW-1:0] nxt_dst;
  logic [LW-1:0] nxt_rem;
  logic [2:0]    first_n;
  logic [2:0]    next_n;

`ifdef BUS_COPY_DMA_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] wait_cnt;
`endif

  // Largest unit allowed by the joint alignment of both pointers and the bytes left.
  function automatic logic [2:0] unit_size(input logic [AW-1:0] s, input logic [AW-1:0] d,
                                           input logic [LW-1:0] r);
    if (s[1:0] == 2'b00 && d[1:0] == 2'b00 && r >= LW'(4)) return 3'd4;
    if (!s[0] && !d[0] && r >= LW'(2)) return 3'd2;
    return 3'd1;
  endfunction

  function automatic logic [ACCW-1:0] acc_code(input logic [2:0] n);
    case (n)
      3'd4:    return `BUS_ACC_4B;
      3'd2:    return `BUS_ACC_2B;
      default: return `BUS_ACC_1B;
    endcase
  endfunction

  function automatic logic [BW-1:0] byte_mask(input logic [2:0] n);
    logic [BW-1:0] m;
    m = '0;
    for (int i = 0; i < int'(BW / 8); i++) begin
      if (i < int'(n)) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

  assign nxt_src = cur_src + AW'(unit_n);
  assign nxt_dst = cur_dst + AW'(unit_n);
  assign nxt_rem = rem - LW'(unit_n);
  assign first_n = unit_size(src, dst, len);
  assign next_n  = unit_size(nxt_src, nxt_dst, nxt_rem);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cur_src  <= '0;
      cur_dst  <= '0;
      rem      <= '0;
      unit_n   <= 3'd1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
      addr     <= '0;
      w_rb     <= 1'b0;
      acc      <= `BUS_ACC_1B;
      wdata    <= '0;
      req      <= 1'b0;
`ifdef BUS_COPY_DMA_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              cur_src  <= src;
              cur_dst  <= dst;
              rem      <= len;
              err_addr <= '0;
              busy     <= 1'b1;
              unit_n   <= first_n;
              acc      <= acc_code(first_n);
              addr     <= src;
              w_rb     <= 1'b0;
              req      <= 1'b1;
`ifdef BUS_COPY_DMA_TIMEOUT_EN
              wait_cnt <= '0;
`endif
              state    <= RD_REQ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RD_REQ, WR_REQ: begin
          // fault is a same-cycle reject of the request just presented
          req <= 1'b0;
          if (fault) begin
            err      <= 1'b1;
            err_addr <= addr;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= (state == RD_REQ) ? RD_WAIT : WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (resp) begin
            wdata <= rdata & byte_mask(unit_n);
            addr  <= cur_dst;
            w_rb  <= 1'b1;
            req   <= 1'b1;
`ifdef BUS_COPY_DMA_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            state <= WR_REQ;
          end
`ifdef BUS_COPY_DMA_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            err      <= 1'b1;
            err_addr <= addr;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        WR_WAIT: begin
          if (resp) begin
            cur_src <= nxt_src;
            cur_dst <= nxt_dst;
            rem     <= nxt_rem;
            if (nxt_rem == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              unit_n <= next_n;
              acc    <= acc_code(next_n);
              addr   <= nxt_src;
              w_rb   <= 1'b0;
              req    <= 1'b1;
`ifdef BUS_COPY_DMA_TIMEOUT_EN
              wait_cnt <= '0;
`endif
              state  <= RD_REQ;
            end
          end
`ifdef BUS_COPY_DMA_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            err      <= 1'b1;
            err_addr <= addr;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_copy_dma.sv
// Self-checking bench for bus_copy_dma: byte-memory responder plus a unit-level copy model.
`timescale 1ns/1ps
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_bus_copy_dma;
  localparam int unsigned AW = 24;
  localparam int unsigned LW = 16;
  localparam int unsigned BW = `BUS_WIDTH;
  localparam int unsigned ACCW = `BUS_ACC_WIDTH;
  localparam int MEMSZ = 4096;
  localparam logic [ACCW-1:0] ACC_1B = `BUS_ACC_1B;
  localparam logic [ACCW-1:0] ACC_2B = `BUS_ACC_2B;
  localparam logic [ACCW-1:0] ACC_4B = `BUS_ACC_4B;

  logic clk = 1'b0;
  logic rstn, start, busy, done, err, w_rb, req, resp, fault;
  logic [AW-1:0] src, dst, err_addr, addr;
  logic [LW-1:0] len;
  logic [ACCW-1:0] acc;
  logic [BW-1:0] rdata, wdata;

  bus_copy_dma #(
    .AW(AW), .LW(LW)
`ifdef BUS_COPY_DMA_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .addr(addr),
    .w_rb(w_rb), .acc(acc), .rdata(rdata), .wdata(wdata), .req(req),
    .resp(resp), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [MEMSZ];
  logic [7:0] ref_mem [MEMSZ];
  logic [AW-1:0]   log_addr[$], exp_addr[$];
  bit              log_wr[$],   exp_wr[$];
  logic [ACCW-1:0] log_acc[$],  exp_acc[$];
  logic [BW-1:0]   log_wdata[$], exp_wdata[$];

  int total = 0, bad = 0;
  int done_cnt = 0, err_cnt = 0, done_busy = 0, req_cnt = 0;
  int lat = 1, pend_cnt = 0;
  bit silent = 0, pending = 0, p_wr = 0;
  logic [AW-1:0] p_addr = '0;
  bit f_en = 0, f_wr = 0;
  logic [AW-1:0] f_addr = '0;

  assign fault = req && f_en && (addr == f_addr) && (w_rb == f_wr);

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a[11:0]);
  endfunction

  function automatic int acc_bytes(input logic [ACCW-1:0] a);
    if (a == ACC_4B) return 4;
    if (a == ACC_2B) return 2;
    return 1;
  endfunction

  function automatic logic [ACCW-1:0] acc_of(input int n);
    if (n == 4) return ACC_4B;
    if (n == 2) return ACC_2B;
    return ACC_1B;
  endfunction

  // Responder and monitor: drives resp/rdata away from the active edge.
  always @(negedge clk) begin
    resp = 1'b0;
    rdata = $urandom;
    if (done) begin done_cnt++; if (busy) done_busy++; end
    if (err) begin err_cnt++; if (busy) done_busy++; end
    if (req) req_cnt++;
    if (pending) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        pending = 0;
        if (!silent) begin
          resp = 1'b1;
          if (!p_wr)
            for (int i = 0; i < 4; i++) rdata[8*i +: 8] = mem[idx(p_addr + AW'(i))];
        end
      end
    end
    if (req && !fault) begin
      log_addr.push_back(addr); log_wr.push_back(w_rb);
      log_acc.push_back(acc); log_wdata.push_back(wdata);
      pending = 1; pend_cnt = lat; p_addr = addr; p_wr = w_rb;
      if (w_rb)
        for (int i = 0; i < acc_bytes(acc); i++) mem[idx(addr + AW'(i))] = wdata[8*i +: 8];
    end
  end

  // Reference: byte-level copy split into units by alignment and bytes left.
  task automatic model_copy(input int s0, input int d0, input int l0);
    int s, d, r, n;
    logic [BW-1:0] data;
    s = s0; d = d0; r = l0;
    while (r > 0) begin
      if (s % 4 == 0 && d % 4 == 0 && r >= 4) n = 4;
      else if (s % 2 == 0 && d % 2 == 0 && r >= 2) n = 2;
      else n = 1;
      data = '0;
      for (int i = 0; i < n; i++) data[8*i +: 8] = ref_mem[(s + i) % MEMSZ];
      exp_addr.push_back(AW'(s)); exp_wr.push_back(1'b0);
      exp_acc.push_back(acc_of(n)); exp_wdata.push_back('0);
      exp_addr.push_back(AW'(d)); exp_wr.push_back(1'b1);
      exp_acc.push_back(acc_of(n)); exp_wdata.push_back(data);
      for (int i = 0; i < n; i++) ref_mem[(d + i) % MEMSZ] = data[8*i +: 8];
      s += n; d += n; r -= n;
    end
  endtask

  task automatic clear_mon();
    log_addr.delete(); log_wr.delete(); log_acc.delete(); log_wdata.delete();
    exp_addr.delete(); exp_wr.delete(); exp_acc.delete(); exp_wdata.delete();
    done_cnt = 0; err_cnt = 0; done_busy = 0; req_cnt = 0;
    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = mem[i];
  endtask

  function automatic int log_mismatches();
    int m = 0;
    if (log_addr.size() != exp_addr.size()) m++;
    for (int i = 0; i < log_addr.size() && i < exp_addr.size(); i++)
      if (log_addr[i] !== exp_addr[i] || log_wr[i] !== exp_wr[i] || log_acc[i] !== exp_acc[i] ||
          (exp_wr[i] && log_wdata[i] !== exp_wdata[i])) m++;
    return m;
  endfunction

  function automatic int mem_mismatches();
    int m = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) m++;
    return m;
  endfunction

  task automatic wait_end(output bit to);
    to = 1;
    for (int c = 0; c < 3000; c++) begin
      if (done || err) begin to = 0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_copy(input int s, input int d, input int l, output bit to);
    @(posedge clk); #1;
    start = 1'b1; src = AW'(s); dst = AW'(d); len = LW'(l);
    @(posedge clk); #1;
    start = 1'b0;
    wait_end(to);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin bad++;
      $display("FAIL reset_flags: busy=%b done=%b err=%b want 0 0 0", busy, done, err); end
    total++; if (req !== 1'b0 || w_rb !== 1'b0) begin bad++;
      $display("FAIL reset_req: req=%b w_rb=%b want 0 0", req, w_rb); end
    total++; if (addr !== '0 || err_addr !== '0) begin bad++;
      $display("FAIL reset_addr: addr=%h err_addr=%h want 0 0", addr, err_addr); end
    total++; if (acc !== ACC_1B || wdata !== '0) begin bad++;
      $display("FAIL reset_acc: acc=%h wdata=%h want %h 0", acc, wdata, ACC_1B); end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_aligned();
    bit to; int m;
    clear_mon(); lat = 2;
    model_copy('h100, 'h200, 8);
    run_copy('h100, 'h200, 8, to);
    total++; if (to) begin bad++; $display("FAIL aligned_timeout: no done/err within bound"); end
    m = log_mismatches();
    total++; if (m !== 0) begin bad++; $display("FAIL aligned_log: mismatches=%0d want 0", m); end
    total++; if (log_addr.size() !== 4) begin bad++;
      $display("FAIL aligned_count: accesses=%0d want 4", log_addr.size()); end
    total++; if (done_cnt !== 1 || err_cnt !== 0 || done_busy !== 0) begin bad++;
      $display("FAIL aligned_done: done=%0d err=%0d busy_at_done=%0d want 1 0 0", done_cnt, err_cnt, done_busy); end
    m = mem_mismatches();
    total++; if (m !== 0) begin bad++; $display("FAIL aligned_mem: bytes_wrong=%0d want 0", m); end
  endtask

  task automatic test_misaligned();
    bit to; int m;
    clear_mon(); lat = 1 + int'($urandom_range(2));
    model_copy('h101, 'h201, 5);
    run_copy('h101, 'h201, 5, to);
    total++; if (to) begin bad++; $display("FAIL misal_timeout: no done/err within bound"); end
    m = log_mismatches();
    total++; if (m !== 0) begin bad++; $display("FAIL misal_log: mismatches=%0d want 0", m); end
    total++; if (log_addr.size() < 6 || log_acc[0] !== ACC_1B || log_addr[4] !== AW'('h104) || log_acc[4] !== ACC_2B)
      begin bad++; $display("FAIL misal_units: n_acc=%0d want 6 with 1B first and 2B at 0x104", log_addr.size()); end
    total++; if (log_wdata.size() < 2 || log_wdata[1][31:8] !== 24'h0) begin bad++;
      $display("FAIL misal_upper: first wdata upper bytes nonzero want 0"); end
    m = mem_mismatches();
    total++; if (m !== 0 || done_cnt !== 1) begin bad++;
      $display("FAIL misal_mem: bytes_wrong=%0d done=%0d want 0 1", m, done_cnt); end
  endtask

  task automatic test_mixed();
    bit to; int m;
    clear_mon(); lat = 1;
    model_copy('h100, 'h102, 4);
    run_copy('h100, 'h102, 4, to);
    m = log_mismatches();
    total++; if (to || m !== 0) begin bad++; $display("FAIL mixed_log: timeout=%0d mismatches=%0d want 0 0", to, m); end
    m = mem_mismatches();
    total++; if (m !== 0 || done_cnt !== 1) begin bad++;
      $display("FAIL mixed_mem: bytes_wrong=%0d done=%0d want 0 1", m, done_cnt); end
  endtask

  task automatic test_zero_len();
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; src = AW'('h50); dst = AW'('h850); len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL zero_done: done=%b busy=%b want 1 0", done, busy); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_pulse: done=%b want 0", done); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (req_cnt !== 0 || done_cnt !== 1) begin bad++;
      $display("FAIL zero_bus: reqs=%0d done=%0d want 0 1", req_cnt, done_cnt); end
  endtask

  task automatic test_fault();
    bit to; int m;
    clear_mon(); lat = 1 + int'($urandom_range(2));
    f_en = 1; f_addr = AW'('h44); f_wr = 1;
    model_copy('h0, 'h40, 8);
    void'(exp_addr.pop_back()); void'(exp_wr.pop_back());
    void'(exp_acc.pop_back()); void'(exp_wdata.pop_back());
    run_copy('h0, 'h40, 8, to);
    f_en = 0;
    total++; if (to || err_cnt !== 1 || done_cnt !== 0) begin bad++;
      $display("FAIL fault_pulse: timeout=%0d err=%0d done=%0d want 0 1 0", to, err_cnt, done_cnt); end
    total++; if (err_addr !== AW'('h44) || busy !== 1'b0) begin bad++;
      $display("FAIL fault_addr: err_addr=%h busy=%b want 44 0", err_addr, busy); end
    m = log_mismatches();
    total++; if (req_cnt !== 4 || m !== 0 || done_busy !== 0) begin bad++;
      $display("FAIL fault_bus: reqs=%0d mismatches=%0d busy_at_err=%0d want 4 0 0", req_cnt, m, done_busy); end
  endtask

  task automatic test_back_to_back();
    bit to; int m;
    clear_mon(); lat = 1;
    model_copy('h10, 'h810, 6);
    model_copy('h20, 'h820, 3);
    @(posedge clk); #1;
    start = 1'b1; src = AW'('h10); dst = AW'('h810); len = LW'(6);
    @(posedge clk); #1;
    start = 1'b0;
    wait_end(to);
    start = 1'b1; src = AW'('h20); dst = AW'('h820); len = LW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (to || busy !== 1'b1) begin bad++;
      $display("FAIL b2b_accept: timeout=%0d busy=%b want 0 1", to, busy); end
    wait_end(to);
    repeat (4) @(posedge clk);
    #1;
    m = log_mismatches();
    total++; if (to || m !== 0 || done_cnt !== 2) begin bad++;
      $display("FAIL b2b_log: timeout=%0d mismatches=%0d done=%0d want 0 0 2", to, m, done_cnt); end
    m = mem_mismatches();
    total++; if (m !== 0) begin bad++; $display("FAIL b2b_mem: bytes_wrong=%0d want 0", m); end
  endtask

  task automatic test_reset_mid();
    bit to; int m, reqs;
    clear_mon(); lat = 6;
    @(posedge clk); #1;
    start = 1'b1; src = AW'('h300); dst = AW'('h900); len = LW'(12);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (log_addr.size() > 0) break;
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    total++; if (req !== 1'b0 || busy !== 1'b0 || addr !== '0 || acc !== ACC_1B) begin bad++;
      $display("FAIL rstmid_outputs: req=%b busy=%b addr=%h acc=%h want 0 0 0 %h", req, busy, addr, acc, ACC_1B); end
    reqs = req_cnt;
    repeat (10) @(posedge clk);
    #1;
    total++; if (req_cnt !== reqs || done_cnt !== 0 || err_cnt !== 0 || busy !== 1'b0) begin bad++;
      $display("FAIL rstmid_late_resp: reqs=%0d done=%0d err=%0d busy=%b want %0d 0 0 0", req_cnt, done_cnt, err_cnt, busy, reqs); end
    clear_mon(); lat = 2;
    model_copy('h304, 'h904, 7);
    run_copy('h304, 'h904, 7, to);
    m = log_mismatches() + mem_mismatches();
    total++; if (to || m !== 0 || done_cnt !== 1) begin bad++;
      $display("FAIL rstmid_restart: timeout=%0d mismatches=%0d done=%0d want 0 0 1", to, m, done_cnt); end
  endtask

  task automatic test_random();
    bit to; int s, d, l, m;
    for (int it = 0; it < 16; it++) begin
      s = int'($urandom_range('h3ff));
      d = 'h800 + int'($urandom_range('h3ff));
      l = int'($urandom_range(20));
      clear_mon(); lat = 1 + int'($urandom_range(3));
      model_copy(s, d, l);
      run_copy(s, d, l, to);
      m = log_mismatches() + mem_mismatches();
      total++; if (to || m !== 0 || done_cnt !== 1 || err_cnt !== 0 || done_busy !== 0) begin bad++;
        $display("FAIL random_%0d: src=%h dst=%h len=%0d timeout=%0d mismatches=%0d done=%0d err=%0d want 0 0 1 0",
                 it, s, d, l, to, m, done_cnt, err_cnt); end
    end
  endtask

`ifdef BUS_COPY_DMA_TIMEOUT_EN
  task automatic test_timeout();
    int c_req, c_err;
    clear_mon(); silent = 1; c_req = -1; c_err = -1;
    @(posedge clk); #1;
    start = 1'b1; src = AW'('h140); dst = AW'('h940); len = LW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (req && c_req < 0) c_req = c;
      if (err) begin c_err = c; break; end
      @(posedge clk); #1;
    end
    silent = 0;
    total++; if (c_err < 0 || c_err - c_req !== 17) begin bad++;
      $display("FAIL timeout_delay: req_cycle=%0d err_cycle=%0d want err 17 cycles after req", c_req, c_err); end
    total++; if (err_addr !== AW'('h140) || busy !== 1'b0 || done_cnt !== 0) begin bad++;
      $display("FAIL timeout_addr: err_addr=%h busy=%b done=%0d want 140 0 0", err_addr, busy, done_cnt); end
    repeat (4) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    resp = 1'b0; rdata = '0;
    test_reset();
    test_aligned();
    test_misaligned();
    test_mixed();
    test_zero_len();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef BUS_COPY_DMA_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
